// File: rtl/gcd_job_sequencer.sv
// gcd_job_sequencer: FIFO-buffered front-end issuing operand pairs to a GCD core and returning results in order
// Ports: in_valid/in_ready/in_a/in_b accept operand pairs; out_valid/out_ready/out_gcd/out_err return results;
// core_go/core_a/core_b/core_rst drive the core, core_done/core_result come back from it;
// fifo_level reports queued pairs, busy is high whenever a job is at the core.
module gcd_job_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_gcd,
  output logic                     out_err,
  output logic                     core_go,
  output logic [WIDTH-1:0]         core_a,
  output logic [WIDTH-1:0]         core_b,
  output logic                     core_rst,
  input  logic                     core_done,
  input  logic [WIDTH-1:0]         core_result,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, GO, WAIT, RECOVER} state_t;
  state_t state;
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [TW-1:0] timer;
  logic push, pop;
  logic [WIDTH-1:0] head_a, head_b;
  assign in_ready = fifo_level != LW'(DEPTH);
  assign push = in_valid & in_ready;
  // a pop only happens from IDLE with room in the output register, so a result is never overwritten
  assign pop = state == IDLE && fifo_level != '0 && !out_valid;
  assign head_a = mem_a[rptr];
  assign head_b = mem_b[rptr];
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wptr] <= in_a;
      mem_b[wptr] <= in_b;
    end
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      fifo_level <= '0;
      state <= IDLE;
      timer <= '0;
      out_valid <= 1'b0;
      out_err <= 1'b0;
      out_gcd <= '0;
      core_go <= 1'b0;
      core_rst <= 1'b0;
      core_a <= '0;
      core_b <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      if (out_valid && out_ready) out_valid <= 1'b0;
      core_go <= 1'b0;
      core_rst <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          core_a <= head_a;
          core_b <= head_b;
          // the core never terminates on a zero operand, so answer those here
          if (head_a == '0 || head_b == '0) begin
            out_gcd <= head_a | head_b;
            out_err <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            core_go <= 1'b1;
            state <= GO;
          end
        end
        GO: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          if (core_done) begin
            out_gcd <= core_result;
            out_err <= 1'b0;
            out_valid <= 1'b1;
            state <= IDLE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            out_gcd <= '0;
            out_err <= 1'b1;
            out_valid <= 1'b1;
            core_rst <= 1'b1;
            state <= RECOVER;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gcd_job_sequencer.sv
// tb_gcd_job_sequencer: directed bench with a result-queue model and a behavioural core stub
module tb_gcd_job_sequencer;
  localparam int W = 8;
  localparam int D = 4;
  localparam int T = 64;
  typedef struct {
    logic [W-1:0] g;
    logic e;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic in_ready, out_valid, out_err, core_go, core_rst, core_done, busy;
  logic [W-1:0] out_gcd, core_a, core_b, core_result;
  logic [2:0] fifo_level;
  logic stub_done = 1'b0;
  logic man_done = 1'b0;
  logic hang_en = 1'b0;
  logic stub_hang = 1'b0;
  logic [W-1:0] sa = '0;
  logic [W-1:0] sb = '0;
  logic [W-1:0] stub_res = '0;
  int stub_delay = 20;
  int stub_cnt = 0;
  int total = 0;
  int bad = 0;
  int go_cnt = 0;
  int crst_cnt = 0;
  int out_cnt = 0;
  exp_t q[$];
  logic [W-1:0] pa [6] = '{8'd48, 8'd21, 8'd100, 8'd17, 8'd64, 8'd27};
  logic [W-1:0] pb [6] = '{8'd18, 8'd14, 8'd75, 8'd5, 8'd48, 8'd9};
  always #5 clk = ~clk;
  assign core_done = stub_done | man_done;
  assign core_result = stub_res;
  gcd_job_sequencer #(.WIDTH(W), .DEPTH(D), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd), .out_err(out_err),
    .core_go(core_go), .core_a(core_a), .core_b(core_b), .core_rst(core_rst),
    .core_done(core_done), .core_result(core_result), .fifo_level(fifo_level), .busy(busy)
  );
  function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic h);
    exp_t r;
    r.e = h && a == 9 && b == 6;
    r.g = r.e ? '0 : (a == 0 || b == 0) ? (a | b) : gcd_f(a, b);
    return r;
  endfunction
  always @(posedge clk) begin
    stub_done <= 1'b0;
    if (core_rst) stub_cnt <= 0;
    else if (core_go) begin
      stub_cnt <= stub_delay - 1;
      stub_hang <= hang_en && core_a == 9 && core_b == 6;
      sa <= core_a;
      sb <= core_b;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1 && !stub_hang) begin
        stub_done <= 1'b1;
        stub_res <= gcd_f(sa, sb);
      end
    end
  end
  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      if (core_go) go_cnt++;
      if (core_rst) crst_cnt++;
      total++;
      if (in_ready !== (fifo_level != D)) begin
        bad++;
        $display("FAIL in_ready act=%b exp=%b", in_ready, fifo_level != D);
      end
      if (out_valid) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL out_unexpected gcd=%0d err=%b", out_gcd, out_err);
        end else begin
          if (out_gcd !== q[0].g || out_err !== q[0].e) begin
            bad++;
            $display("FAIL out_result act=%0d/%b exp=%0d/%b", out_gcd, out_err, q[0].g, q[0].e);
          end
          if (out_ready) begin
            void'(q.pop_front());
            out_cnt++;
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_a, in_b, hang_en));
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", n, act, exp);
    end
  endtask
  task automatic wait_out(input int lim, output int n);
    n = 0;
    while (!out_valid && n < lim) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL wait_out waited=%0d limit=%0d", n, lim);
    end
  endtask
  task automatic push1(input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    tick();
    in_valid = 1'b0;
  endtask
  initial begin
    int n, g0, c0, r0, idx;
    logic acc;
    repeat (2) tick();
    chk("rst_level", fifo_level, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_gcd", out_gcd, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_core_go", core_go, 0);
    chk("rst_core_rst", core_rst, 0);
    chk("rst_core_a", core_a, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    g0 = go_cnt;
    push1(48, 18);
    chk("t1_level_e0", fifo_level, 1);
    chk("t1_go_e0", core_go, 0);
    tick();
    chk("t1_go_e1", core_go, 1);
    chk("t1_a_e1", core_a, 48);
    chk("t1_b_e1", core_b, 18);
    chk("t1_busy_e1", busy, 1);
    chk("t1_level_e1", fifo_level, 0);
    tick();
    chk("t1_go_e2", core_go, 0);
    repeat (10) tick();
    chk("t1_a_mid", core_a, 48);
    chk("t1_b_mid", core_b, 18);
    chk("t1_busy_mid", busy, 1);
    wait_out(100, n);
    chk("t1_latency", n, 10);
    chk("t1_gcd", out_gcd, 6);
    chk("t1_err", out_err, 0);
    chk("t1_busy_after", busy, 0);
    chk("t1_go_count", go_cnt - g0, 1);
    tick();
    g0 = go_cnt;
    in_valid = 1'b1;
    in_a = 0;
    in_b = 35;
    tick();
    in_a = 0;
    in_b = 0;
    tick();
    in_valid = 1'b0;
    chk("t2_valid_a", out_valid, 1);
    chk("t2_gcd_a", out_gcd, 35);
    chk("t2_err_a", out_err, 0);
    chk("t2_busy", busy, 0);
    tick();
    chk("t2_cleared", out_valid, 0);
    tick();
    chk("t2_valid_b", out_valid, 1);
    chk("t2_gcd_b", out_gcd, 0);
    tick();
    chk("t2_no_go", go_cnt - g0, 0);
    out_ready = 1'b0;
    stub_delay = 10;
    idx = 0;
    c0 = out_cnt;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_a = pa[idx];
      in_b = pb[idx];
      acc = in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("t3_accepted", idx, 5);
    chk("t3_in_ready", in_ready, 0);
    chk("t3_level", fifo_level, 4);
    chk("t3_first_gcd", out_gcd, 6);
    out_ready = 1'b1;
    for (int i = 0; i < 300 && !(out_cnt - c0 == 5 && !busy && !out_valid); i++) tick();
    chk("t3_drained", out_cnt - c0, 5);
    chk("t3_level_end", fifo_level, 0);
    hang_en = 1'b1;
    r0 = crst_cnt;
    in_valid = 1'b1;
    in_a = 9;
    in_b = 6;
    tick();
    in_a = 10;
    in_b = 4;
    tick();
    in_valid = 1'b0;
    tick();
    wait_out(200, n);
    chk("t4_timeout_cycles", n, 64);
    chk("t4_err", out_err, 1);
    chk("t4_gcd", out_gcd, 0);
    chk("t4_core_rst", core_rst, 1);
    tick();
    chk("t4_core_rst_end", core_rst, 0);
    wait_out(100, n);
    chk("t4_next_gcd", out_gcd, 2);
    chk("t4_next_err", out_err, 0);
    chk("t4_rst_pulses", crst_cnt - r0, 1);
    hang_en = 1'b0;
    tick();
    stub_delay = 64;
    r0 = crst_cnt;
    push1(30, 12);
    repeat (2) tick();
    wait_out(200, n);
    chk("t5_edge_cycles", n, 64);
    chk("t5_edge_gcd", out_gcd, 6);
    chk("t5_edge_err", out_err, 0);
    tick();
    chk("t5_no_core_rst", crst_cnt - r0, 0);
    chk("t5_busy", busy, 0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_a = 0;
    in_b = 5;
    tick();
    in_b = 6;
    tick();
    in_b = 7;
    tick();
    in_valid = 1'b0;
    chk("t5_level2", fifo_level, 2);
    chk("t5_gcd5", out_gcd, 5);
    out_ready = 1'b1;
    tick();
    chk("t5_level_hold", fifo_level, 2);
    chk("t5_cleared", out_valid, 0);
    in_valid = 1'b1;
    in_b = 8;
    tick();
    in_valid = 1'b0;
    chk("t5_push_pop_level", fifo_level, 2);
    chk("t5_gcd6", out_gcd, 6);
    for (int i = 0; i < 50 && (fifo_level != 0 || out_valid); i++) tick();
    chk("t5_drain", fifo_level, 0);
    stub_delay = 50;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a = pa[i];
      in_b = pb[i];
      tick();
    end
    in_valid = 1'b0;
    repeat (5) tick();
    chk("t6_busy_pre", busy, 1);
    chk("t6_level_pre", fifo_level, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_level", fifo_level, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_core_go", core_go, 0);
    chk("t6_busy", busy, 0);
    g0 = go_cnt;
    repeat (60) tick();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    tick();
    chk("t6_done_ignored", out_valid, 0);
    chk("t6_idle", busy, 0);
    chk("t6_no_go", go_cnt - g0, 0);
    stub_delay = 5;
    in_valid = 1'b1;
    in_a = 12;
    in_b = 0;
    tick();
    in_a = 21;
    in_b = 14;
    tick();
    in_valid = 1'b0;
    wait_out(50, n);
    chk("t6_mix_a", out_gcd, 12);
    tick();
    wait_out(50, n);
    chk("t6_mix_b", out_gcd, 7);
    chk("t6_mix_err", out_err, 0);
    repeat (3) tick();
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
